// File: rtl/itcm_access_arbiter_pkg.sv
// rtl/itcm_access_arbiter_pkg.sv - shared ITCM width and response owner-tag encodings
package itcm_access_arbiter_pkg;

  localparam int ITCM_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IFU  = 2'd1,
    OWNER_LSU  = 2'd2,
    OWNER_DBG  = 2'd3
  } owner_e;

endpackage

// File: rtl/itcm_access_arbiter.sv
// rtl/itcm_access_arbiter.sv - single-port ITCM arbiter (dbg > lsu > ifu) with IFU starvation guard
module itcm_access_arbiter
  import itcm_access_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = ITCM_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dbg_req_i,
  input  logic                  dbg_we_i,
  input  logic [3:0]            dbg_be_i,
  input  logic [31:0]           dbg_addr_i,
  input  logic [31:0]           dbg_wdata_i,
  output logic                  dbg_gnt_o,
  output logic                  dbg_rvalid_o,
  output logic [31:0]           dbg_rdata_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [3:0]            lsu_be_i,
  input  logic [31:0]           lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [31:0]           lsu_rdata_o,
  input  logic                  ifu_req_i,
  input  logic [31:0]           ifu_addr_i,
  output logic                  ifu_gnt_o,
  output logic                  ifu_rvalid_o,
  output logic [31:0]           ifu_rdata_o,
  output logic                  ram_cs_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [ADDR_WIDTH-3:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic [31:0]           ifu_stall_cnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_e      win;
  owner_e      owner_q;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] stall_q, stall_d;
  logic        ifu_stall;
  logic        unused_addr_bits;

  // Only [ADDR_WIDTH-1:2] of each address reaches the SRAM.
  assign unused_addr_bits = ^{dbg_addr_i, lsu_addr_i, ifu_addr_i};

  always_comb begin
    win = OWNER_NONE;
    if (rst)                                   win = OWNER_NONE;
    else if (dbg_req_i)                        win = OWNER_DBG;
    else if (ifu_req_i && starve_q == LIMIT)   win = OWNER_IFU;
    else if (lsu_req_i)                        win = OWNER_LSU;
    else if (ifu_req_i)                        win = OWNER_IFU;
  end

  assign dbg_gnt_o = (win == OWNER_DBG);
  assign lsu_gnt_o = (win == OWNER_LSU);
  assign ifu_gnt_o = (win == OWNER_IFU);
  assign ram_cs_o  = (win != OWNER_NONE);

  always_comb begin
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = '0;
    ram_wdata_o = 32'h0;
    case (win)
      OWNER_DBG: begin
        ram_we_o    = dbg_we_i;
        ram_be_o    = dbg_be_i;
        ram_addr_o  = dbg_addr_i[ADDR_WIDTH-1:2];
        ram_wdata_o = dbg_wdata_i;
      end
      OWNER_LSU: begin
        ram_we_o    = lsu_we_i;
        ram_be_o    = lsu_be_i;
        ram_addr_o  = lsu_addr_i[ADDR_WIDTH-1:2];
        ram_wdata_o = lsu_wdata_i;
      end
      OWNER_IFU: begin
        ram_be_o   = 4'hF;
        ram_addr_o = ifu_addr_i[ADDR_WIDTH-1:2];
      end
      default: ;
    endcase
  end

  assign ifu_stall = ifu_req_i && !ifu_gnt_o;

  always_comb begin
    starve_d = 4'd0;
    if (ifu_stall) starve_d = (starve_q < LIMIT) ? starve_q + 4'd1 : starve_q;
    stall_d = ifu_stall ? stall_q + 32'd1 : stall_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWNER_NONE;
      starve_q <= 4'd0;
      stall_q  <= 32'd0;
    end else begin
      owner_q  <= win;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // Gating with rst drops the response of an access granted just before reset.
  assign dbg_rvalid_o = (owner_q == OWNER_DBG) && !rst;
  assign lsu_rvalid_o = (owner_q == OWNER_LSU) && !rst;
  assign ifu_rvalid_o = (owner_q == OWNER_IFU) && !rst;

  assign dbg_rdata_o     = ram_rdata_i;
  assign lsu_rdata_o     = ram_rdata_i;
  assign ifu_rdata_o     = ram_rdata_i;
  assign ifu_stall_cnt_o = stall_q;

endmodule

// File: doc/itcm_access_arbiter.md
# itcm_access_arbiter

Arbiter sharing the single-port ITCM SRAM of `u_mems` between three requesters: the debug/loader port (JTAG or UART program download), the LSU data port and the IFU fetch port. It grants at most one access per cycle and returns read data with a fixed one-cycle latency. A starvation guard guarantees IFU forward progress under continuous LSU traffic. It also keeps a stall counter that simulation monitors sample for cycle accounting.

## Interface
Parameters:
- `ADDR_WIDTH`, default `` `ITCM_ADDR_WIDTH ``: byte-address width of the ITCM; the SRAM word address is `[ADDR_WIDTH-1:2]`.
- `STARVE_LIMIT`, default 4: number of consecutive denied IFU request cycles after which IFU outranks LSU; legal range 1..15.

Ports:
- `clk` in 1: clock; the block uses a single clock.
- `rst` in 1: reset, synchronous, active-high.
- `dbg_req_i` in 1; `dbg_we_i` in 1; `dbg_be_i` in 4; `dbg_addr_i` in 32; `dbg_wdata_i` in 32: loader request.
- `dbg_gnt_o` out 1; `dbg_rvalid_o` out 1; `dbg_rdata_o` out 32: loader grant and response.
- `lsu_req_i`, `lsu_we_i`, `lsu_be_i`, `lsu_addr_i`, `lsu_wdata_i`: LSU request, same widths as the loader.
- `lsu_gnt_o`, `lsu_rvalid_o`, `lsu_rdata_o`: LSU grant and response.
- `ifu_req_i` in 1; `ifu_addr_i` in 32: fetch request, read-only.
- `ifu_gnt_o` out 1; `ifu_rvalid_o` out 1; `ifu_rdata_o` out 32: fetch grant and response.
- `ram_cs_o` out 1; `ram_we_o` out 1; `ram_be_o` out 4; `ram_addr_o` out ADDR_WIDTH-2; `ram_wdata_o` out 32: SRAM command.
- `ram_rdata_i` in 32: SRAM read data, valid the cycle after a `ram_cs_o` read.
- `ifu_stall_cnt_o` out 32: count of cycles with `ifu_req_i && !ifu_gnt_o`.

## Operation
- **Priority:** dbg > lsu > ifu.
- **Starvation override:** when `starve_cnt == STARVE_LIMIT`, IFU outranks LSU but never outranks dbg.
- **starve_cnt** is 4 bits.
  - Increments on `ifu_req_i && !ifu_gnt_o`, saturating at STARVE_LIMIT.
  - Clears on an IFU grant or on `!ifu_req_i`.
- **Grant:** exactly one `*_gnt_o` is asserted when any request is active, and none otherwise. A grant means the access is issued to the SRAM that same cycle.
- **SRAM mux:** `ram_cs_o` = any grant. `ram_we_o`, `ram_be_o`, `ram_addr_o` and `ram_wdata_o` come from the winner.
  - IFU accesses drive `we=0` and `be=4'hF`.
  - When idle, all `ram_*` outputs are 0.
- **Addressing:** `ram_addr_o = addr[ADDR_WIDTH-1:2]`. Bits [1:0] and bits above ADDR_WIDTH are ignored; alignment is the requester's responsibility.
- **Response:** the owner tag is registered each cycle (NONE/IFU/LSU/DBG). Next cycle, the owner's `*_rvalid_o` pulses for one cycle.
  - `rvalid` pulses for writes too, as a write acknowledge; `rdata` is undefined for writes.
- **Read data:** all three `*_rdata_o` are wired directly to `ram_rdata_i`. Consumers qualify with `rvalid`.
- **Stall counter:** `ifu_stall_cnt_o` wraps modulo 2^32.

## Timing
- **Reset values:** all `*_gnt_o`, `ram_cs_o` and `*_rvalid_o` are 0, the owner tag is NONE, `starve_cnt` is 0 and `ifu_stall_cnt_o` is 0.
  - While `rst` is high, grants and `ram_cs_o` are forced to 0.
- **Grant path:** grant is combinational from the requests in the same cycle (req→gnt, zero latency). Requesters hold request fields stable until granted.
- **Read latency:** exactly 1 cycle from grant to `rvalid`.
- **Throughput:** one access per cycle. Back-to-back grants to different owners are allowed, and responses stay in order because latency is fixed.
- **Reset mid-operation:** `rst` asserted the cycle after a grant suppresses that response. No `rvalid` appears.
- **Simultaneous dbg+lsu+ifu with `starve_cnt == LIMIT`:** dbg wins and `starve_cnt` holds at LIMIT.
- **IFU withdraws its request before grant:** `starve_cnt` clears and `ifu_stall_cnt_o` stops counting that cycle.

## Structure
- Owner-tag encodings (NONE=0, IFU=1, LSU=2, DBG=3) and `ITCM_ADDR_WIDTH` belong in the shared `defines.v`.
- One module with no sub-modules. The priority pick, starvation counter and response register are each too small to warrant splitting.

## Test plan
- **LSU hold-off:** lsu_req continuous, ifu_req continuous, STARVE_LIMIT=4 → LSU granted on cycles 0-3; IFU granted on cycle 4 and every 5th cycle thereafter; `ifu_stall_cnt_o` = 4 after cycle 4.
- **Loader lockout:** dbg writes words 0..15 (addr 0x0..0x3C, be=F) while IFU requests → IFU never granted for 16 cycles; then an IFU read of 0x8 returns the word written there, with `ifu_rvalid_o` 1 cycle after grant.
- **Byte write:** LSU write be=4'b0010 data 0xAABBCCDD to 0x100 over an existing 0x11223344 → a later read of 0x100 returns 0x1122CC44.
- **Interleaved owners:** alternating LSU read 0x4 / IFU read 0x8 every cycle → each rvalid lands only on its owner, in order, 1 cycle later.
- **Reset mid-operation:** `rst` asserted the cycle after an LSU read grant → `lsu_rvalid_o` stays 0; all counters read 0 after release.
- **Idle:** no requests → `ram_cs_o`=0, all grants 0, counters unchanged.
